// File: rtl/melody_pkg.sv
// ============================================================================
// Module   : melody_pkg
// Brief    : Shared widths, rest threshold and FSM encoding for melody_player.
// Revision : 1.0
// ============================================================================
`default_nettype none

package melody_pkg;

  localparam int INDEX_W  = 10;
  localparam int NOTE_W   = 20;
  localparam int DUR_W    = 5;
  localparam int REST_MAX = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  // A zero-length entry still plays for one unit so the unit count never underflows.
  function automatic logic [DUR_W-1:0] load_units(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/melody_player_tone_gen.sv
// ============================================================================
// Module   : tone_gen
// Brief    : Half-period counter producing the square-wave speaker signal.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tone_gen
  import melody_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [NOTE_W-1:0] half_period,
  output logic              speaker
);

  logic [NOTE_W-1:0] half_cnt_q, half_cnt_d;
  logic              speaker_q, speaker_d;

  always_comb begin
    half_cnt_d = half_cnt_q;
    speaker_d  = speaker_q;
    if (clear || !enable || (half_period <= NOTE_W'(REST_MAX))) begin
      half_cnt_d = '0;
      speaker_d  = 1'b0;
    end else if (half_cnt_q == half_period - NOTE_W'(1)) begin
      half_cnt_d = '0;
      speaker_d  = ~speaker_q;
    end else begin
      half_cnt_d = half_cnt_q + NOTE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
      speaker_q  <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      speaker_q  <= speaker_d;
    end
  end

  assign speaker = speaker_q;

endmodule

`default_nettype wire

// File: rtl/melody_player.sv
// ============================================================================
// Module   : melody_player
// Brief    : Steps through a melody lookup, holding each note for its duration
//            and driving the speaker. Optional macro MELODY_ARTICULATION_EN
//            silences the last GAP_CYCLES of every note.
// Revision : 1.0
// ============================================================================
`default_nettype none

module melody_player
  import melody_pkg::*;
#(
  parameter int UNIT_CYCLES = 6_250_000,
  parameter int LAST_INDEX  = 48,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [INDEX_W-1:0] number,
  input  logic [NOTE_W-1:0]  note,
  input  logic [DUR_W-1:0]   duration,
  output logic               speaker,
  output logic               playing,
  output logic               done
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0]      UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0]      GAP_START = UW'(UNIT_CYCLES - GAP_CYCLES);
  localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(LAST_INDEX);
`ifdef MELODY_ARTICULATION_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] number_q, number_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   units_q, units_d;
  logic [UW-1:0]      unit_cnt_q, unit_cnt_d;
  logic               done_q, done_d;
  logic               gap_d;
  logic               tone_clear;

  always_comb begin
    state_d    = state_q;
    number_d   = number_q;
    note_d     = note_q;
    units_d    = units_q;
    unit_cnt_d = unit_cnt_q;
    done_d     = 1'b0;
    if (stop) begin
      state_d    = IDLE;
      number_d   = '0;
      unit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          number_d = '0;
          if (start) state_d = LOAD;
        end
        LOAD: begin
          note_d     = note;
          units_d    = load_units(duration);
          unit_cnt_d = '0;
          state_d    = PLAY;
        end
        PLAY: begin
          if (unit_cnt_q == UNIT_LAST) begin
            unit_cnt_d = '0;
            if (units_q == DUR_W'(1)) begin
              if (number_q < LAST_IDX) begin
                number_d = number_q + INDEX_W'(1);
                state_d  = LOAD;
              end else if (loop_en) begin
                number_d = '0;
                state_d  = LOAD;
              end else begin
                number_d = '0;
                state_d  = IDLE;
                done_d   = 1'b1;
              end
            end else begin
              units_d = units_q - DUR_W'(1);
            end
          end else begin
            unit_cnt_d = unit_cnt_q + UW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Silence is decided from next-cycle values so the registered speaker is
  // already low on the first cycle of the gap and on the LOAD cycle.
  always_comb begin
    gap_d      = GAP_EN && (state_d == PLAY) && (units_d == DUR_W'(1)) &&
                 (unit_cnt_d >= GAP_START);
    tone_clear = (state_d != PLAY) || gap_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      number_q   <= '0;
      note_q     <= '0;
      units_q    <= '0;
      unit_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      note_q     <= note_d;
      units_q    <= units_d;
      unit_cnt_q <= unit_cnt_d;
      done_q     <= done_d;
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (tone_clear),
    .enable      (state_q == PLAY),
    .half_period (note_q),
    .speaker     (speaker)
  );

  assign number  = number_q;
  assign playing = (state_q != IDLE);
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_melody_player.sv
// ============================================================================
// Module   : tb_melody_player
// Brief    : Randomized self-checking bench for melody_player against a
//            cycle-position model of the melody.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_melody_player;

  localparam int U    = 8;
  localparam int LAST = 2;
  localparam int GAP  = 2;
`ifdef MELODY_ARTICULATION_EN
  localparam int MGAP = GAP;
`else
  localparam int MGAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [9:0]  number;
  logic [19:0] note;
  logic [4:0]  duration;
  logic        speaker, playing, done;

  always #5 clk = ~clk;

  melody_player #(
    .UNIT_CYCLES (U),
    .LAST_INDEX  (LAST),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .number   (number),
    .note     (note),
    .duration (duration),
    .speaker  (speaker),
    .playing  (playing),
    .done     (done)
  );

  always_comb begin
    case (number)
      10'd0:   begin note = 20'd3; duration = 5'd2;  end
      10'd1:   begin note = 20'd1; duration = 5'd1;  end
      10'd2:   begin note = 20'd5; duration = 5'd0;  end
      default: begin note = 20'd9; duration = 5'd16; end
    endcase
  end

  function automatic int note_of(input int i);
    case (i)
      0: return 3;
      1: return 1;
      2: return 5;
      default: return 9;
    endcase
  endfunction

  function automatic int units_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 1;
      default: return 16;
    endcase
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the current entry (0 = load cycle, 1.. = tone cycles).
  bit m_busy;
  int m_idx;
  int m_pos;
  bit m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
      m_pos  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (stop) begin
        m_busy <= 1'b0;
        m_idx  <= 0;
        m_pos  <= 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_idx  <= 0;
          m_pos  <= 0;
        end
      end else if (m_pos == units_of(m_idx) * U) begin
        m_pos <= 0;
        if (m_idx < LAST) begin
          m_idx <= m_idx + 1;
        end else if (loop_en) begin
          m_idx <= 0;
        end else begin
          m_idx  <= 0;
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic int exp_speaker();
    int k, n;
    if (!m_busy || m_pos == 0) return 0;
    k = m_pos - 1;
    n = note_of(m_idx);
    if (n < 2) return 0;
    if (k >= units_of(m_idx) * U - MGAP) return 0;
    return (k / n) % 2;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("playing", 32'(playing), 32'(m_busy));
      check("number",  32'(number),  32'(m_idx));
      check("done",    32'(done),    32'(m_done));
      check("speaker", 32'(speaker), 32'(exp_speaker()));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_playing", 32'(playing), 0);
    check("reset_number",  32'(number),  0);
    check("reset_speaker", 32'(speaker), 0);
    check("reset_done",    32'(done),    0);
    rst_n = 1'b1;
    @(negedge clk);

    // One pass without looping; t is the cycle start is sampled.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_number",  32'(number),  0);
    check("start_playing", 32'(playing), 1);
    @(negedge clk);
    check("play_entry_speaker", 32'(speaker), 0);
    repeat (3) @(negedge clk);
    check("first_toggle", 32'(speaker), 1);
    repeat (13) @(negedge clk);
    check("second_entry_number", 32'(number), 1);
    repeat (18) @(negedge clk);
    check("done_pulse",   32'(done),    1);
    check("done_playing", 32'(playing), 0);
    check("done_number",  32'(number),  0);
    check("done_speaker", 32'(speaker), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);

    // Looping pass.
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);
    check("wrap_number",  32'(number),  0);
    check("wrap_playing", 32'(playing), 1);
    check("wrap_no_done", 32'(done),    0);
    repeat (40) @(negedge clk);

    // Stop with a simultaneous start while playing entry 0.
    check("pre_stop_number", 32'(number), 0);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    check("stop_playing", 32'(playing), 0);
    check("stop_number",  32'(number),  0);
    check("stop_speaker", 32'(speaker), 0);
    check("stop_done",    32'(done),    0);

    // Restart, then reset asynchronously mid-tone.
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_number",  32'(number),  0);
    check("restart_playing", 32'(playing), 1);
    repeat (10) @(negedge clk);
    check("pre_reset_speaker", 32'(speaker), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_playing", 32'(playing), 0);
    check("async_number",  32'(number),  0);
    check("async_speaker", 32'(speaker), 0);
    check("async_done",    32'(done),    0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 30) == 0;
      stop  = ($urandom % 150) == 0;
      if (($urandom % 200) == 0) loop_en = ~loop_en;
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
